// File: rtl/fetch_pc_ctrl_if.sv
// rtl/fetch_pc_ctrl_if.sv - fetch PC controller signal bundle
//
// Groups the fetch, M/W stage and prediction signals of fetch_pc_ctrl.
//   master : pipeline side, drives fetch/M/W inputs and observes the prediction outputs
//   slave  : fetch_pc_ctrl itself
// Optional FETCH_PERF_EN adds perf_ret_stall / perf_mispred / perf_stall.
interface fetch_pc_ctrl_if;
    logic        f_valid;
    logic [3:0]  f_icode;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic        F_stall;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [3:0]  W_icode;
    logic [63:0] F_predPC;
    logic        f_bubble;
    logic        ret_pending;
    logic        halted;
    logic        ret_timeout;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_ret_stall;
    logic [31:0] perf_mispred;
    logic [31:0] perf_stall;
`endif

    modport master (
        output f_valid, f_icode, f_valC, f_valP, F_stall, M_icode, M_cnd, W_icode,
        input  F_predPC, f_bubble, ret_pending, halted, ret_timeout
`ifdef FETCH_PERF_EN
        , input perf_ret_stall, perf_mispred, perf_stall
`endif
    );

    modport slave (
        input  f_valid, f_icode, f_valC, f_valP, F_stall, M_icode, M_cnd, W_icode,
        output F_predPC, f_bubble, ret_pending, halted, ret_timeout
`ifdef FETCH_PERF_EN
        , output perf_ret_stall, perf_mispred, perf_stall
`endif
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - Y86-64 fetch-side F register and next-PC predictor
//
// Holds F_predPC and predicts the next PC from the instruction just fetched
// (jXX predicted taken, call -> target, otherwise fall-through). A RUN/RET_WAIT/HALT
// FSM bubbles fetch while a ret travels to W and freezes fetch on halt; a jXX
// mispredict seen in M cancels either.
//
// Ports:
//   clk          clock, all state on posedge
//   rst          asynchronous active-high reset
//   bus.slave    f_valid/f_icode/f_valC/f_valP/F_stall, M_icode/M_cnd, W_icode in;
//                F_predPC, f_bubble (registered), ret_pending, halted (from state),
//                ret_timeout (sticky) out
// Parameters:
//   RESET_PC     F_predPC value after reset
//   RET_TIMEOUT  RET_WAIT cycles without a W ret before ret_timeout sets (>=4)
// Configuration:
//   FETCH_PERF_EN  adds 32-bit wrapping counters perf_ret_stall, perf_mispred, perf_stall
module fetch_pc_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          RET_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst,
    fetch_pc_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(RET_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RET_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RET_TIMEOUT - 1);

    localparam logic [3:0] I_HALT = 4'd0;
    localparam logic [3:0] I_JXX  = 4'd7;
    localparam logic [3:0] I_CALL = 4'd8;
    localparam logic [3:0] I_RET  = 4'd9;
    localparam logic [3:0] I_MAX  = 4'd11;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_RET_WAIT = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [63:0]      pred_pc;
    logic             f_bubble_q;
    logic             ret_timeout_q;

    logic [63:0] pred;
    logic        mispred;
    logic        w_ret;
    logic        f_is_ret;
    logic        f_is_halt;
    logic        take_fetch;

    assign pred      = (bus.f_icode == I_JXX || bus.f_icode == I_CALL) ? bus.f_valC : bus.f_valP;
    assign mispred   = (bus.M_icode == I_JXX) && !bus.M_cnd;
    assign w_ret     = (bus.W_icode == I_RET);
    assign f_is_ret  = (bus.f_icode == I_RET);
    assign f_is_halt = (bus.f_icode == I_HALT) || (bus.f_icode > I_MAX);

    // An instruction is accepted into F in RUN when not stalled, and in RET_WAIT only
    // on the cycle the ret reaches W (the PC mux is taking W_valM then).
    assign take_fetch = bus.f_valid &&
                        (((state == S_RUN) && !bus.F_stall) ||
                         ((state == S_RET_WAIT) && w_ret));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_RUN;
            wait_cnt      <= '0;
            pred_pc       <= RESET_PC;
            f_bubble_q    <= 1'b0;
            ret_timeout_q <= 1'b0;
        end else if (mispred) begin
            // Wrong-path instruction is squashed: no ret/halt decode this cycle.
            state      <= S_RUN;
            wait_cnt   <= '0;
            f_bubble_q <= 1'b0;
            if (bus.f_valid) begin
                pred_pc <= pred;
            end
        end else begin
            case (state)
                S_RUN: begin
                    if (take_fetch) begin
                        f_bubble_q <= 1'b0;
                    end
                end
                S_RET_WAIT: begin
                    if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                    if (w_ret) begin
                        state      <= S_RUN;
                        f_bubble_q <= 1'b0;
                    end else begin
                        f_bubble_q <= 1'b1;
                        if (wait_cnt == CNT_LAST) begin
                            ret_timeout_q <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    f_bubble_q <= 1'b1;
                end
                default: begin
                    state <= S_RUN;
                end
            endcase

            // Later assignments override the case above for a freshly fetched ret/halt.
            if (take_fetch) begin
                pred_pc <= pred;
                if (f_is_ret) begin
                    state      <= S_RET_WAIT;
                    f_bubble_q <= 1'b1;
                    wait_cnt   <= '0;
                end else if (f_is_halt) begin
                    state      <= S_HALT;
                    f_bubble_q <= 1'b1;
                end
            end
        end
    end

    assign bus.F_predPC    = pred_pc;
    assign bus.f_bubble    = f_bubble_q;
    assign bus.ret_pending = (state == S_RET_WAIT);
    assign bus.halted      = (state == S_HALT);
    assign bus.ret_timeout = ret_timeout_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_ret_stall_q;
    logic [31:0] perf_mispred_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ret_stall_q <= '0;
            perf_mispred_q   <= '0;
            perf_stall_q     <= '0;
        end else begin
            if (state == S_RET_WAIT) begin
                perf_ret_stall_q <= perf_ret_stall_q + 32'd1;
            end
            if (mispred) begin
                perf_mispred_q <= perf_mispred_q + 32'd1;
            end
            if ((state == S_RUN) && bus.F_stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign bus.perf_ret_stall = perf_ret_stall_q;
    assign bus.perf_mispred   = perf_mispred_q;
    assign bus.perf_stall     = perf_stall_q;
`endif
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - self-checking bench for fetch_pc_ctrl
module tb_fetch_pc_ctrl;
    localparam logic [63:0] RESET_PC    = 64'h0000_0000_0000_0100;
    localparam int          RET_TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_pc_ctrl_if bus ();

    fetch_pc_ctrl #(.RESET_PC(RESET_PC), .RET_TIMEOUT(RET_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: flags for "waiting on a ret" / "halted" plus the age of the wait.
    logic [63:0] m_pc;
    bit          m_bubble, m_waiting, m_halted, m_tmo;
    int          m_age;

    function automatic void model_reset();
        m_pc = RESET_PC; m_bubble = 0; m_waiting = 0; m_halted = 0; m_tmo = 0; m_age = 0;
    endfunction

    function automatic void model_accept(input logic [63:0] p, input logic [3:0] ic);
        m_pc = p;
        if (ic == 4'd9) begin
            m_waiting = 1; m_age = 0; m_bubble = 1;
        end else if (ic == 4'd0 || ic > 4'd11) begin
            m_halted = 1; m_bubble = 1;
        end
    endfunction

    function automatic void model_step();
        logic [63:0] p;
        p = (bus.f_icode == 4'd7 || bus.f_icode == 4'd8) ? bus.f_valC : bus.f_valP;
        if (bus.M_icode == 4'd7 && !bus.M_cnd) begin
            m_waiting = 0; m_halted = 0; m_age = 0; m_bubble = 0;
            if (bus.f_valid) m_pc = p;
        end else if (m_halted) begin
            m_bubble = 1;
        end else if (m_waiting) begin
            m_age = m_age + 1;
            if (bus.W_icode == 4'd9) begin
                m_waiting = 0; m_bubble = 0;
                if (bus.f_valid) model_accept(p, bus.f_icode);
            end else begin
                m_bubble = 1;
                if (m_age >= RET_TIMEOUT) m_tmo = 1;
            end
        end else if (!bus.F_stall && bus.f_valid) begin
            m_bubble = 0;
            model_accept(p, bus.f_icode);
        end
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".pc"},     bus.F_predPC,    m_pc);
        check_eq({tag, ".bubble"}, bus.f_bubble,    m_bubble);
        check_eq({tag, ".retp"},   bus.ret_pending, m_waiting);
        check_eq({tag, ".halted"}, bus.halted,      m_halted);
        check_eq({tag, ".tmo"},    bus.ret_timeout, m_tmo);
    endtask

    task automatic set_f(input bit v, input logic [3:0] ic, input logic [63:0] c, input logic [63:0] p);
        bus.f_valid = v; bus.f_icode = ic; bus.f_valC = c; bus.f_valP = p;
    endtask

    task automatic idle();
        set_f(0, 4'd1, 64'h0, 64'h0);
        bus.F_stall = 0; bus.M_icode = 4'd0; bus.M_cnd = 1; bus.W_icode = 4'd0;
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse between edges; outputs checked before any clock edge.
    task automatic reset_pulse(input string tag);
        #2 rst = 1;
        #1;
        model_reset();
        check_eq({tag, ".rst_pc"},  bus.F_predPC,    RESET_PC);
        check_eq({tag, ".rst_bub"}, bus.f_bubble,    64'd0);
        check_eq({tag, ".rst_rp"},  bus.ret_pending, 64'd0);
        check_eq({tag, ".rst_tmo"}, bus.ret_timeout, 64'd0);
        check_eq({tag, ".rst_hlt"}, bus.halted,      64'd0);
        #1 rst = 0;
    endtask

    function automatic logic [3:0] rand_icode();
        int r;
        logic [3:0] plain [8];
        plain = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11};
        r = $urandom_range(0, 99);
        if (r < 6)  return 4'd9;
        if (r < 8)  return 4'($urandom_range(12, 15));
        if (r < 9)  return 4'd0;
        if (r < 25) return 4'd7;
        if (r < 35) return 4'd8;
        return plain[$urandom_range(0, 7)];
    endfunction

    initial begin
        rst = 1;
        idle();
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk) rst = 0;
        cycle("idle");

        // jXX predicted taken, then fall-through
        set_f(1, 4'd7, 64'h40, 64'h0A); cycle("t2a");
        check_eq("t2a.const", bus.F_predPC, 64'h40);
        set_f(1, 4'd3, 64'h0, 64'h14); cycle("t2b");
        check_eq("t2b.const", bus.F_predPC, 64'h14);

        // call then ret; 3 bubble cycles until W ret
        set_f(1, 4'd8, 64'h200, 64'h1E); cycle("t3call");
        check_eq("t3call.const", bus.F_predPC, 64'h200);
        set_f(1, 4'd9, 64'h0, 64'h201); cycle("t3ret");
        check_eq("t3ret.bub", bus.f_bubble, 64'd1);
        set_f(0, 4'd1, 64'h0, 64'h0);
        cycle("t3w1"); check_eq("t3w1.bub", bus.f_bubble, 64'd1);
        cycle("t3w2"); check_eq("t3w2.bub", bus.f_bubble, 64'd1);
        bus.W_icode = 4'd9; set_f(1, 4'd3, 64'h0, 64'h300); cycle("t3wret");
        check_eq("t3wret.bub", bus.f_bubble, 64'd0);
        check_eq("t3wret.rp",  bus.ret_pending, 64'd0);
        check_eq("t3wret.pc",  bus.F_predPC, 64'h300);
        bus.W_icode = 4'd0;

        // F_stall holds the F register
        bus.F_stall = 1;
        set_f(1, 4'd3, 64'h0, 64'h20); cycle("t4s1");
        set_f(1, 4'd3, 64'h0, 64'h2A); cycle("t4s2");
        check_eq("t4.hold", bus.F_predPC, 64'h300);
        bus.F_stall = 0;

        // halt, then mispredict recovers
        set_f(1, 4'd0, 64'h0, 64'h50); cycle("t5halt");
        check_eq("t5.halted", bus.halted, 64'd1);
        set_f(1, 4'd3, 64'h0, 64'h60); cycle("t5hold");
        check_eq("t5.hold", bus.F_predPC, 64'h50);
        bus.M_icode = 4'd7; bus.M_cnd = 0; set_f(1, 4'd3, 64'h0, 64'h30); cycle("t5mis");
        check_eq("t5.pc", bus.F_predPC, 64'h30);
        check_eq("t5.bub", bus.f_bubble, 64'd0);
        check_eq("t5.run", bus.halted, 64'd0);
        bus.M_icode = 4'd0; bus.M_cnd = 1;

        // mispredict and W ret together: mispredict wins, a ret fetched then is squashed
        set_f(1, 4'd9, 64'h0, 64'h70); cycle("t7ret");
        bus.M_icode = 4'd7; bus.M_cnd = 0; bus.W_icode = 4'd9;
        set_f(1, 4'd9, 64'h0, 64'h80); cycle("t7both");
        check_eq("t7.rp", bus.ret_pending, 64'd0);
        check_eq("t7.pc", bus.F_predPC, 64'h80);
        idle();

        // ret timeout: sets after RET_TIMEOUT waiting cycles, sticky past W ret
        set_f(1, 4'd9, 64'h0, 64'h90); cycle("t6ret");
        set_f(0, 4'd1, 64'h0, 64'h0);
        for (int i = 0; i < RET_TIMEOUT - 1; i++) cycle("t6wait");
        check_eq("t6.early", bus.ret_timeout, 64'd0);
        cycle("t6last");
        check_eq("t6.tmo", bus.ret_timeout, 64'd1);
        bus.W_icode = 4'd9; cycle("t6wret");
        check_eq("t6.sticky", bus.ret_timeout, 64'd1);
        bus.W_icode = 4'd0;
        cycle("t6after");

        // reset mid-run clears everything
        set_f(1, 4'd9, 64'h0, 64'hA0); cycle("t1ret");
        reset_pulse("t1");
        idle();
        cycle("t1post");

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            set_f($urandom_range(0, 3) != 0, rand_icode(), {$urandom, $urandom}, {$urandom, $urandom});
            bus.F_stall = ($urandom_range(0, 3) == 0);
            bus.M_icode = ($urandom_range(0, 15) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
            bus.M_cnd   = $urandom_range(0, 1);
            bus.W_icode = ($urandom_range(0, 9) == 0) ? 4'd9 : 4'($urandom_range(0, 8));
            if ($urandom_range(0, 299) == 0) reset_pulse("rnd");
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
